// File: rtl/alu_result_fifo.sv
// First-word-fall-through result buffer behind the 8-bit ALU.
// Captures result, opcode and {C,N,Z} flags per entry.
// Optional per-entry parity output when ALU_RESFIFO_PARITY_EN is defined.
module alu_result_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OPW   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           res_in,
    input  logic [OPW-1:0]             op_in,
    input  logic                       carry_in,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic [WIDTH-1:0]           res_out,
    output logic [OPW-1:0]             op_out,
    output logic [2:0]                 flags_out,
`ifdef ALU_RESFIFO_PARITY_EN
    output logic                       parity_out,
`endif
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic [7:0]                 stall_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] res_mem [DEPTH];
    logic [OPW-1:0]   op_mem  [DEPTH];
    logic [2:0]       flg_mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [7:0]    stall_q, stall_d;

    logic          push, pop;
    logic [2:0]    flags_new;

    assign in_ready  = (count_q < CW'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;
    assign stall_cnt = stall_q;

    assign flags_new = {carry_in, res_in[WIDTH-1], (res_in == '0)};

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        stall_d  = stall_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (in_valid && !in_ready && (stall_q != 8'hFF)) begin
            stall_d = stall_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
        end
    end

    // Storage is not reset; outputs are masked by out_valid instead.
    always_ff @(posedge clk) begin
        if (push) begin
            res_mem[wr_ptr_q] <= res_in;
            op_mem[wr_ptr_q]  <= op_in;
            flg_mem[wr_ptr_q] <= flags_new;
        end
    end

    always_comb begin
        res_out   = '0;
        op_out    = '0;
        flags_out = '0;
        if (out_valid) begin
            res_out   = res_mem[rd_ptr_q];
            op_out    = op_mem[rd_ptr_q];
            flags_out = flg_mem[rd_ptr_q];
        end
    end

`ifdef ALU_RESFIFO_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (push) begin
            par_mem[wr_ptr_q] <= ^{op_in, res_in};
        end
    end

    assign parity_out = out_valid ? par_mem[rd_ptr_q] : 1'b0;
`endif

endmodule
